// File: rtl/neuron_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : neuron_seq_ctrl
// Description : Layer-evaluation sequencer for the neuron datapath. For each
//               neuron it streams input/weight pairs out of the memories,
//               accumulates the signed products, compares the sum against a
//               latched threshold and records one spike bit per neuron.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_seq_ctrl #(
  parameter int N_INPUTS  = 64,
  parameter int N_NEURONS = 8,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 22,
  parameter int RD_LAT    = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      abort,
  input  logic signed [ACC_W-1:0]                   threshold,
  output logic [$clog2(N_INPUTS)-1:0]               in_rd_addr,
  output logic [$clog2(N_INPUTS*N_NEURONS)-1:0]     w_rd_addr,
  output logic                                      mem_rd_en,
  input  logic signed [DATA_W-1:0]                  in_data,
  input  logic signed [DATA_W-1:0]                  w_data,
  output logic                                      busy,
  output logic                                      done,
  output logic [N_NEURONS-1:0]                      spike_out,
  output logic                                      spike_valid,
  output logic signed [ACC_W-1:0]                   acc_out
);

  localparam int IW  = $clog2(N_INPUTS);
  localparam int NW  = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int DW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int WAW = $clog2(N_INPUTS * N_NEURONS);
  localparam int PW  = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_DRAIN   = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nx;
  logic [IW-1:0]            r_idx;
  logic [NW-1:0]            r_neuron;
  logic [DW-1:0]            r_drain;
  logic [RD_LAT-1:0]        r_vld;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_thr;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic                     w_accept;
  logic                     w_last_idx;
  logic                     w_last_neuron;
  logic                     w_last_drain;

  // Full-precision signed product, sign-extended into the accumulator width
  assign w_prod     = in_data * w_data;
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};

  // A start is only taken in IDLE and loses to a simultaneous abort
  assign w_accept      = (r_state == S_IDLE) && start && !abort;
  assign w_last_idx    = (r_idx == IW'(N_INPUTS - 1));
  assign w_last_neuron = (r_neuron == NW'(N_NEURONS - 1));
  assign w_last_drain  = (r_drain == DW'(RD_LAT - 1));

  // Weight memory is laid out neuron-major, so the address is neuron*N_INPUTS+idx
  assign in_rd_addr = r_idx;
  assign w_rd_addr  = WAW'(r_neuron) * WAW'(N_INPUTS) + WAW'(r_idx);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state decode and state-derived control outputs
  always_comb begin
    w_state_nx = r_state;
    mem_rd_en  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        mem_rd_en = 1'b1;
        if (abort)           w_state_nx = S_IDLE;
        else if (w_last_idx) w_state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)             w_state_nx = S_IDLE;
        else if (w_last_drain) w_state_nx = S_COMPARE;
      end
      S_COMPARE: begin
        if (abort)              w_state_nx = S_IDLE;
        else if (w_last_neuron) w_state_nx = S_DONE;
        else                    w_state_nx = S_ISSUE;
      end
      S_DONE: begin
        // An abort landing on the completion cycle suppresses the pulse
        done       = !abort;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Read-valid pipeline: mirrors the memory latency so products line up with strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else if (abort) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= mem_rd_en;
      for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  // Index, neuron and drain counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_neuron <= '0;
      r_drain  <= '0;
    end else begin
      if (w_accept) begin
        r_idx    <= '0;
        r_neuron <= '0;
      end else if (r_state == S_ISSUE && !abort) begin
        r_idx <= r_idx + 1'b1;
      end else if (r_state == S_COMPARE && !abort && !w_last_neuron) begin
        r_idx    <= '0;
        r_neuron <= r_neuron + 1'b1;
      end
      if (r_state == S_DRAIN && !abort) r_drain <= r_drain + 1'b1;
      else                              r_drain <= '0;
    end
  end

  // Accumulator: cleared on start, per-neuron compare and abort; wraps mod 2^ACC_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (abort || w_accept || r_state == S_COMPARE) begin
      r_acc <= '0;
    end else if (r_vld[RD_LAT-1]) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  // Threshold latch and result registers (spike bits, last sum, valid flag)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_thr       <= '0;
      spike_out   <= '0;
      spike_valid <= 1'b0;
      acc_out     <= '0;
    end else if (w_accept) begin
      r_thr       <= threshold;
      spike_out   <= '0;
      spike_valid <= 1'b0;
    end else if (!abort) begin
      if (r_state == S_COMPARE) begin
        spike_out[r_neuron] <= (r_acc >= r_thr);
        acc_out             <= r_acc;
      end
      if (r_state == S_DONE) spike_valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_neuron_seq_ctrl
// Description : Directed self-checking bench for neuron_seq_ctrl (default
//               parameters, single-cycle read memory model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_seq_ctrl;

  localparam int NI      = 64;
  localparam int NN      = 8;
  localparam int DW      = 8;
  localparam int AW      = 22;
  localparam int RL      = 1;
  localparam int RUN_CYC = NN * (NI + RL + 1) + 1;  // 529

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic signed [AW-1:0] threshold;
  logic [5:0]           in_rd_addr;
  logic [8:0]           w_rd_addr;
  logic                 mem_rd_en;
  logic signed [DW-1:0] in_data = '0;
  logic signed [DW-1:0] w_data  = '0;
  logic                 busy;
  logic                 done;
  logic [NN-1:0]        spike_out;
  logic                 spike_valid;
  logic signed [AW-1:0] acc_out;

  int n_checks = 0;
  int n_errors = 0;

  neuron_seq_ctrl #(
    .N_INPUTS (NI),
    .N_NEURONS(NN),
    .DATA_W   (DW),
    .ACC_W    (AW),
    .RD_LAT   (RL)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .threshold  (threshold),
    .in_rd_addr (in_rd_addr),
    .w_rd_addr  (w_rd_addr),
    .mem_rd_en  (mem_rd_en),
    .in_data    (in_data),
    .w_data     (w_data),
    .busy       (busy),
    .done       (done),
    .spike_out  (spike_out),
    .spike_valid(spike_valid),
    .acc_out    (acc_out)
  );

  always #5 clk = ~clk;

  // Memory contents and a one-cycle-latency read model
  logic signed [DW-1:0] in_mem [NI];
  logic signed [DW-1:0] w_mem  [NI*NN];
  logic                 rd_pend = 1'b0;
  logic [5:0]           ia_pend = '0;
  logic [8:0]           wa_pend = '0;
  int                   strobes  = 0;
  int                   exp_addr = 0;
  bit                   addr_bad = 1'b0;

  // Sample the read request mid-cycle and track address contiguity
  always @(negedge clk) begin
    rd_pend = mem_rd_en;
    ia_pend = in_rd_addr;
    wa_pend = w_rd_addr;
    if (mem_rd_en === 1'b1) begin
      if (w_rd_addr !== 9'(exp_addr) || in_rd_addr !== 6'(exp_addr)) addr_bad = 1'b1;
      exp_addr++;
      strobes++;
    end
  end

  // Return read data on the edge that closes the strobe cycle
  always @(posedge clk) begin
    if (rd_pend) begin
      in_data <= in_mem[ia_pend];
      w_data  <= w_mem[wa_pend];
    end
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // mode 0: all ones; mode 1: in=1, weight sign by neuron parity; mode 2: all -128
  task automatic fill(input int mode);
    for (int i = 0; i < NI; i++) in_mem[i] = (mode == 2) ? -8'sd128 : 8'sd1;
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < NI; i++)
        case (mode)
          1:       w_mem[n*NI+i] = (n % 2 == 0) ? 8'sd1 : -8'sd1;
          2:       w_mem[n*NI+i] = -8'sd128;
          default: w_mem[n*NI+i] = 8'sd1;
        endcase
  endtask

  // Wait for done with a cycle budget; returns cycles counted from the start edge
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (cnt < RUN_CYC + 50) begin
      @(negedge clk);
      cnt++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic run_layer(input string tag, input int thr, input int exp_spk,
                           input int exp_acc);
    int cnt;
    @(negedge clk);
    threshold = AW'(thr);
    start     = 1'b1;
    strobes   = 0;
    exp_addr  = 0;
    addr_bad  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cnt   = 1;
    if (done !== 1'b1) begin
      wait_done(cnt);
      cnt++;
    end
    check({tag, "_done_cycle"}, cnt, RUN_CYC);
    check({tag, "_spike"}, 32'(spike_out), exp_spk);
    check({tag, "_acc"}, 32'(acc_out), exp_acc);
    check({tag, "_valid_during_done"}, 32'(spike_valid), 0);
    check({tag, "_strobes"}, strobes, NI*NN);
    check({tag, "_addr_seq"}, 32'(addr_bad), 0);
    @(negedge clk);
    check({tag, "_valid_after"}, 32'(spike_valid), 1);
    check({tag, "_idle_busy"}, 32'(busy), 0);
    check({tag, "_done_one_cycle"}, 32'(done), 0);
  endtask

  initial begin
    int cnt;
    int ndone;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    threshold = '0;
    fill(0);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_spike", 32'(spike_out), 0);
    check("rst_valid", 32'(spike_valid), 0);
    check("rst_acc", 32'(acc_out), 0);
    check("rst_waddr", 32'(w_rd_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    // All ones: every sum 64, equals threshold
    fill(0);
    run_layer("ones", 64, 8'hFF, 64);

    // Alternating weight sign per neuron
    fill(1);
    run_layer("alt", 0, 8'h55, -64);

    // Largest products, sum at 2^20 without overflow
    fill(2);
    run_layer("max_eq", 1048576, 8'hFF, 1048576);
    run_layer("max_gt", 1048577, 8'h00, 1048576);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 0);

    // Abort during neuron 3 issue phase (cycles 199..262)
    fill(1);
    threshold = '0;
    start = 1'b1;
    cnt = 0;
    repeat (210) begin
      @(negedge clk);
      start = 1'b0;
      cnt++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_rd_en", 32'(mem_rd_en), 0);
    check("abort_busy", 32'(busy), 0);
    ndone = 0;
    repeat (RUN_CYC) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_valid", 32'(spike_valid), 0);
    check("abort_partial_spike", 32'(spike_out), 8'h05);
    run_layer("after_abort", 0, 8'h55, -64);

    // start held and re-pulsed while busy, then back-to-back restart
    @(negedge clk);
    threshold = '0;
    start = 1'b1;
    cnt = 0;
    ndone = 0;
    while (cnt < RUN_CYC + 50 && ndone == 0) begin
      @(negedge clk);
      cnt++;
      start = (cnt < 100) || (cnt == 300);
      if (done === 1'b1) ndone++;
    end
    check("held_done_cycle", cnt, RUN_CYC);
    @(negedge clk);
    check("b2b_valid_set", 32'(spike_valid), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_accepted_busy", 32'(busy), 1);
    check("b2b_valid_dropped", 32'(spike_valid), 0);
    wait_done(cnt);
    check("b2b_done_cycle", cnt + 1, RUN_CYC);
    check("b2b_spike", 32'(spike_out), 8'h55);
    @(negedge clk);
    check("b2b_valid_reasserted", 32'(spike_valid), 1);

    // Reset mid-run returns to reset values immediately
    fill(0);
    threshold = 22'sd10;
    start = 1'b1;
    repeat (150) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rd_en", 32'(mem_rd_en), 0);
    check("midrst_spike", 32'(spike_out), 0);
    check("midrst_acc", 32'(acc_out), 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("midrst_no_done", ndone, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
